// File: rtl/mem_arbiter_if.sv
// Word-granular memory port shared by both cache links and the backing-memory link.
// A request (ren or wen) is taken in any cycle where ready=1. ready reflects registered
// state only. valid is a one-cycle read-response pulse that carries rdata.
interface mem_arbiter_if;
  logic        ready;
  logic [31:0] addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        valid;

  modport master (output addr, ren, wen, wdata, input ready, rdata, valid);
  modport slave  (input addr, ren, wen, wdata, output ready, rdata, valid);
endinterface

// File: rtl/mem_arbiter.sv
// Merges the icache and dcache memory ports onto one backing-memory port. There is a
// one-entry request buffer per cache, round-robin issue, and in-order read-response routing.
module mem_arbiter #(
  parameter int RESP_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    icache,
  mem_arbiter_if.slave    dcache,
  mem_arbiter_if.master   mem,
  output logic            orphan
);

  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(RESP_DEPTH);

  logic        ib_valid, ib_write;
  logic [31:0] ib_addr, ib_wdata;
  logic        db_valid, db_write;
  logic [31:0] db_addr, db_wdata;

  // Routing FIFO holds the source id of each outstanding read: 0=icache, 1=dcache.
  logic [RESP_DEPTH-1:0] fifo_id;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  rr_ptr;

  logic [31:0] i_rdata_q, d_rdata_q;

  logic i_accept, d_accept;
  logic fifo_empty, pop, room;
  logic i_elig, d_elig, grant_i, grant_d;
  logic push, head_id, i_resp, d_resp;

  assign icache.ready = ~ib_valid;
  assign dcache.ready = ~db_valid;
  assign i_accept     = ~ib_valid & (icache.ren | icache.wen);
  assign d_accept     = ~db_valid & (dcache.ren | dcache.wen);

  assign fifo_empty = (count == '0);
  assign pop        = mem.valid & ~fifo_empty;
  assign orphan     = mem.valid & fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a read.
  assign room       = (count != FULL_COUNT) | pop;

  assign i_elig  = ib_valid & (ib_write | room);
  assign d_elig  = db_valid & (db_write | room);
  assign grant_d = mem.ready & d_elig & (~i_elig | rr_ptr);
  assign grant_i = mem.ready & i_elig & ~grant_d;

  always_comb begin
    mem.addr  = '0;
    mem.wdata = '0;
    mem.ren   = 1'b0;
    mem.wen   = 1'b0;
    if (grant_i) begin
      mem.addr  = ib_addr;
      mem.wdata = ib_wdata;
      mem.ren   = ~ib_write;
      mem.wen   = ib_write;
    end else if (grant_d) begin
      mem.addr  = db_addr;
      mem.wdata = db_wdata;
      mem.ren   = ~db_write;
      mem.wen   = db_write;
    end
  end

  assign push    = (grant_i & ~ib_write) | (grant_d & ~db_write);
  assign head_id = fifo_id[rd_ptr];
  assign i_resp  = pop & ~head_id;
  assign d_resp  = pop & head_id;

  assign icache.valid = i_resp;
  assign icache.rdata = i_resp ? mem.rdata : i_rdata_q;
  assign dcache.valid = d_resp;
  assign dcache.rdata = d_resp ? mem.rdata : d_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ib_valid  <= 1'b0;
      ib_write  <= 1'b0;
      ib_addr   <= '0;
      ib_wdata  <= '0;
      db_valid  <= 1'b0;
      db_write  <= 1'b0;
      db_addr   <= '0;
      db_wdata  <= '0;
      fifo_id   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rr_ptr    <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      // Accept and issue never coincide: accept needs an empty buffer, issue a full one.
      if (i_accept) begin
        ib_valid <= 1'b1;
        ib_write <= icache.wen;
        ib_addr  <= icache.addr;
        ib_wdata <= icache.wdata;
      end else if (grant_i) begin
        ib_valid <= 1'b0;
      end
      if (d_accept) begin
        db_valid <= 1'b1;
        db_write <= dcache.wen;
        db_addr  <= dcache.addr;
        db_wdata <= dcache.wdata;
      end else if (grant_d) begin
        db_valid <= 1'b0;
      end

      if (grant_i)      rr_ptr <= 1'b1;
      else if (grant_d) rr_ptr <= 1'b0;

      if (push) begin
        fifo_id[wr_ptr] <= grant_d;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);

      if (i_resp) i_rdata_q <= mem.rdata;
      if (d_resp) d_rdata_q <= mem.rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. It covers single reads, arbitration, posted writes under
// backpressure, FIFO-full hold, orphan responses after reset, and an interleaved stream.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic orphan;

  always #5 clk = ~clk;

  mem_arbiter_if i_bus ();
  mem_arbiter_if d_bus ();
  mem_arbiter_if m_bus ();

  mem_arbiter #(.RESP_DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .icache (i_bus),
    .dcache (d_bus),
    .mem    (m_bus),
    .orphan (orphan)
  );

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    i_bus.ren = 1'b0; i_bus.wen = 1'b0; i_bus.addr = '0; i_bus.wdata = '0;
    d_bus.ren = 1'b0; d_bus.wen = 1'b0; d_bus.addr = '0; d_bus.wdata = '0;
    m_bus.ready = 1'b1; m_bus.valid = 1'b0; m_bus.rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ni, nd, nissue;
    logic [31:0] e;

    idle();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    sample();
    check("rst_i_ready", i_bus.ready, 1);
    check("rst_d_ready", d_bus.ready, 1);
    check("rst_mem_ren", m_bus.ren, 0);
    check("rst_mem_wen", m_bus.wen, 0);
    check("rst_mem_addr", m_bus.addr, 0);
    check("rst_i_valid", i_bus.valid, 0);
    check("rst_d_valid", d_bus.valid, 0);
    check("rst_i_rdata", i_bus.rdata, 0);
    check("rst_orphan", orphan, 0);

    // Single icache read with a memory latency of 2 cycles.
    next_cycle(); i_bus.ren = 1'b1; i_bus.addr = 32'h100;
    sample(); check("t1_accept_ready", i_bus.ready, 1);
    next_cycle(); i_bus.ren = 1'b0;
    sample();
    check("t1_ren", m_bus.ren, 1);
    check("t1_addr", m_bus.addr, 32'h100);
    check("t1_busy", i_bus.ready, 0);
    next_cycle(); sample();
    check("t1_ren_once", m_bus.ren, 0);
    check("t1_ready_back", i_bus.ready, 1);
    next_cycle(); m_bus.valid = 1'b1; m_bus.rdata = 32'h12345678;
    sample();
    check("t1_i_valid", i_bus.valid, 1);
    check("t1_i_rdata", i_bus.rdata, 32'h12345678);
    check("t1_d_valid", d_bus.valid, 0);
    next_cycle(); m_bus.valid = 1'b0; m_bus.rdata = 32'h0;
    sample();
    check("t1_i_valid_off", i_bus.valid, 0);
    check("t1_i_rdata_hold", i_bus.rdata, 32'h12345678);

    // Posted dcache write held off by i_mem_ready=0 for 3 cycles.
    next_cycle();
    d_bus.wen = 1'b1; d_bus.addr = 32'h200; d_bus.wdata = 32'hDEADBEEF; m_bus.ready = 1'b0;
    sample(); check("t3_accept_ready", d_bus.ready, 1);
    for (int k = 0; k < 3; k++) begin
      next_cycle(); d_bus.wen = 1'b0;
      sample();
      check("t3_d_busy", d_bus.ready, 0);
      check("t3_no_wen", m_bus.wen, 0);
    end
    next_cycle(); m_bus.ready = 1'b1;
    sample();
    check("t3_wen", m_bus.wen, 1);
    check("t3_ren", m_bus.ren, 0);
    check("t3_addr", m_bus.addr, 32'h200);
    check("t3_wdata", m_bus.wdata, 32'hDEADBEEF);
    next_cycle(); sample();
    check("t3_wen_once", m_bus.wen, 0);
    check("t3_ready_back", d_bus.ready, 1);
    next_cycle(); m_bus.valid = 1'b1; m_bus.rdata = 32'h55;
    sample();
    check("t3_orphan", orphan, 1);
    check("t3_d_valid", d_bus.valid, 0);
    check("t3_i_valid", i_bus.valid, 0);

    // Both ports request together with the pointer on icache.
    next_cycle(); m_bus.valid = 1'b0;
    i_bus.ren = 1'b1; i_bus.addr = 32'h40; d_bus.ren = 1'b1; d_bus.addr = 32'h80;
    next_cycle(); i_bus.ren = 1'b0; d_bus.ren = 1'b0;
    sample();
    check("t2_first_ren", m_bus.ren, 1);
    check("t2_first_addr", m_bus.addr, 32'h40);
    next_cycle(); sample();
    check("t2_second_ren", m_bus.ren, 1);
    check("t2_second_addr", m_bus.addr, 32'h80);
    next_cycle(); m_bus.valid = 1'b1; m_bus.rdata = 32'hAAAA;
    sample();
    check("t2_i_valid", i_bus.valid, 1);
    check("t2_i_rdata", i_bus.rdata, 32'hAAAA);
    check("t2_d_quiet", d_bus.valid, 0);
    next_cycle(); m_bus.rdata = 32'hBBBB;
    sample();
    check("t2_d_valid", d_bus.valid, 1);
    check("t2_d_rdata", d_bus.rdata, 32'hBBBB);
    check("t2_i_quiet", i_bus.valid, 0);
    next_cycle(); m_bus.valid = 1'b0;

    // Four dcache reads fill the FIFO; the fifth waits for the first response.
    for (int k = 0; k < 5; k++) begin
      next_cycle(); d_bus.ren = 1'b1; d_bus.addr = 32'h300 + 32'(4 * k);
      sample(); check("t4_accept", d_bus.ready, 1);
      next_cycle(); d_bus.ren = 1'b0;
      sample();
      if (k < 4) begin
        check("t4_ren", m_bus.ren, 1);
        check("t4_addr", m_bus.addr, 32'h300 + 32'(4 * k));
        exp_q.push_back(32'hD000_0000 + 32'(k));
      end else begin
        check("t4_held", m_bus.ren, 0);
      end
    end
    next_cycle(); sample();
    check("t4_still_held", m_bus.ren, 0);
    check("t4_d_busy", d_bus.ready, 0);
    for (int r = 0; r < 5; r++) begin
      next_cycle(); m_bus.valid = 1'b1; m_bus.rdata = 32'hD000_0000 + 32'(r);
      sample();
      if (r == 0) begin
        check("t4_fifth_ren", m_bus.ren, 1);
        check("t4_fifth_addr", m_bus.addr, 32'h310);
        exp_q.push_back(32'hD000_0004);
      end
      check("t4_d_valid", d_bus.valid, 1);
      check("t4_i_quiet", i_bus.valid, 0);
      if (exp_q.size() == 0) begin
        check("t4_exp_q_empty", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("t4_d_rdata", d_bus.rdata, e);
      end
    end
    next_cycle(); m_bus.valid = 1'b0;
    sample(); check("t4_d_valid_off", d_bus.valid, 0);

    // Reset with two reads outstanding; late responses become orphans.
    next_cycle();
    i_bus.ren = 1'b1; i_bus.addr = 32'h500; d_bus.ren = 1'b1; d_bus.addr = 32'h600;
    next_cycle(); i_bus.ren = 1'b0; d_bus.ren = 1'b0;
    sample(); check("t5_first_addr", m_bus.addr, 32'h500);
    next_cycle(); sample(); check("t5_second_addr", m_bus.addr, 32'h600);
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    sample();
    check("t5_i_ready", i_bus.ready, 1);
    check("t5_d_ready", d_bus.ready, 1);
    for (int r = 0; r < 2; r++) begin
      next_cycle(); m_bus.valid = 1'b1; m_bus.rdata = 32'hEEEE_0000 + 32'(r);
      sample();
      check("t5_orphan", orphan, 1);
      check("t5_i_valid", i_bus.valid, 0);
      check("t5_d_valid", d_bus.valid, 0);
      check("t5_i_rdata_reset", i_bus.rdata, 0);
    end
    next_cycle(); m_bus.valid = 1'b0;
    sample(); check("t5_orphan_off", orphan, 0);

    // icache line fill interleaved with a dcache write-through stream.
    ni = 0; nd = 0; nissue = 0;
    for (int c = 0; c < 30 && nissue < 8; c++) begin
      next_cycle();
      if (i_bus.ready && ni < 4) begin
        i_bus.ren = 1'b1; i_bus.addr = 32'h1000 + 32'(4 * ni); ni++;
      end else begin
        i_bus.ren = 1'b0;
      end
      if (d_bus.ready && nd < 4) begin
        d_bus.wen = 1'b1; d_bus.addr = 32'h2000 + 32'(4 * nd);
        d_bus.wdata = 32'hC0DE_0000 + 32'(nd); nd++;
      end else begin
        d_bus.wen = 1'b0;
      end
      sample();
      if (m_bus.ren || m_bus.wen) begin
        check("t6_kind", 32'(m_bus.wen), 32'(nissue % 2));
        if (nissue % 2 == 0) begin
          check("t6_i_addr", m_bus.addr, 32'h1000 + 32'(4 * (nissue / 2)));
        end else begin
          check("t6_d_addr", m_bus.addr, 32'h2000 + 32'(4 * (nissue / 2)));
          check("t6_d_wdata", m_bus.wdata, 32'hC0DE_0000 + 32'(nissue / 2));
        end
        nissue++;
      end
    end
    check("t6_issue_count", 32'(nissue), 8);
    next_cycle(); i_bus.ren = 1'b0; d_bus.wen = 1'b0;
    for (int r = 0; r < 4; r++) begin
      m_bus.valid = 1'b1; m_bus.rdata = 32'hF111_0000 + 32'(r);
      sample();
      check("t6_i_valid", i_bus.valid, 1);
      check("t6_i_rdata", i_bus.rdata, 32'hF111_0000 + 32'(r));
      check("t6_d_quiet", d_bus.valid, 0);
      next_cycle();
    end
    m_bus.valid = 1'b0;
    sample();
    check("t6_fifo_drained_ready", i_bus.ready, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
